// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the processor datapath.
// The controller takes the master side; the datapath and memories take the slave side.
interface multicycle_controller_if #(
    parameter int unsigned INSTR_W = 19
);
    // Datapath and memory status seen by the controller
    logic [INSTR_W-1:0] instr;
    logic               zero;
    logic               carry;
    logic               imem_ready;
    logic               dmem_ready;

    // Datapath control lines driven by the controller
    logic               imem_req;
    logic               ir_load;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               rst_pc;
    logic               rst_flags;
    logic [2:0]         alu_fn;
    logic               alu_src_imm;
    logic               r2_sel;
    logic [1:0]         sh_fn;
    logic [1:0]         wb_sel;
    logic               reg_write;
    logic               flags_en;
    logic               dmem_read;
    logic               dmem_write;
    logic               stack_push;
    logic               stack_pop;
    logic               illegal;

    modport master (
        input  instr, zero, carry, imem_ready, dmem_ready,
        output imem_req, ir_load, pc_write, pc_src, rst_pc, rst_flags,
               alu_fn, alu_src_imm, r2_sel, sh_fn, wb_sel, reg_write, flags_en,
               dmem_read, dmem_write, stack_push, stack_pop, illegal
    );

    modport slave (
        output instr, zero, carry, imem_ready, dmem_ready,
        input  imem_req, ir_load, pc_write, pc_src, rst_pc, rst_flags,
               alu_fn, alu_src_imm, r2_sel, sh_fn, wb_sel, reg_write, flags_en,
               dmem_read, dmem_write, stack_push, stack_pop, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: sequences RST/FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath control lines combinationally from state and IR, and tracks the
// return-address stack depth so over/underflowing calls are trapped as illegal.
module multicycle_controller #(
    parameter int unsigned INSTR_W     = 19,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   rst,
    multicycle_controller_if.master bus
);
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] OP_ALU    = 3'b000;
    localparam logic [2:0] OP_ALUI   = 3'b001;
    localparam logic [2:0] OP_MEM    = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b101;
    localparam logic [2:0] OP_SHIFT  = 3'b110;
    localparam logic [2:0] OP_JUMP   = 3'b111;

    localparam logic [2:0] FN_LDM = 3'b000;
    localparam logic [2:0] FN_JMP = 3'b000;
    localparam logic [2:0] FN_JSR = 3'b001;
    localparam logic [2:0] FN_RET = 3'b010;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [CNT_W-1:0] stackCount;
    logic [2:0]       op;
    logic [2:0]       fn;
    logic             stackFull;
    logic             stackEmpty;
    logic             decIllegal;
    logic             branchTaken;
    logic             unusedInstrBits;

    assign op = bus.instr[INSTR_W-1 -: 3];
    assign fn = bus.instr[INSTR_W-4 -: 3];
    // Operand fields below the function code belong to the datapath only.
    assign unusedInstrBits = ^bus.instr[INSTR_W-7:0];

    assign stackFull  = (stackCount == CNT_W'(STACK_DEPTH));
    assign stackEmpty = (stackCount == '0);

    // Opcode/function classification, including stack over/underflow traps
    always_comb begin
        decIllegal = 1'b0;
        case (op)
            3'b010, 3'b011: decIllegal = 1'b1;
            OP_MEM:         decIllegal = (fn[2:1] != 2'b00);
            OP_JUMP: begin
                case (fn)
                    FN_JMP:  decIllegal = 1'b0;
                    FN_JSR:  decIllegal = stackFull;
                    FN_RET:  decIllegal = stackEmpty;
                    default: decIllegal = 1'b1;
                endcase
            end
            default:        decIllegal = 1'b0;
        endcase
    end

    // Branch condition from the flags as they stand in EXEC
    always_comb begin
        case (fn[1:0])
            2'b00:   branchTaken = bus.zero;
            2'b01:   branchTaken = ~bus.zero;
            2'b10:   branchTaken = bus.carry;
            default: branchTaken = ~bus.carry;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= nextState;
        end
    end

    // Return-stack depth, updated on the JSR/RET strobes
    always_ff @(posedge clock) begin
        if (rst) begin
            stackCount <= '0;
        end else if (bus.stack_push) begin
            stackCount <= stackCount + CNT_W'(1);
        end else if (bus.stack_pop) begin
            stackCount <= stackCount - CNT_W'(1);
        end
    end

    // Next-state and control-line decode
    always_comb begin
        nextState       = state;
        bus.imem_req    = 1'b0;
        bus.ir_load     = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'b00;
        bus.rst_pc      = 1'b0;
        bus.rst_flags   = 1'b0;
        bus.alu_fn      = 3'b000;
        bus.alu_src_imm = 1'b0;
        bus.r2_sel      = 1'b0;
        bus.sh_fn       = 2'b00;
        bus.wb_sel      = 2'b00;
        bus.reg_write   = 1'b0;
        bus.flags_en    = 1'b0;
        bus.dmem_read   = 1'b0;
        bus.dmem_write  = 1'b0;
        bus.stack_push  = 1'b0;
        bus.stack_pop   = 1'b0;
        bus.illegal     = 1'b0;

        case (state)
            S_RST: begin
                bus.rst_pc    = 1'b1;
                bus.rst_flags = 1'b1;
                nextState     = S_FETCH;
            end

            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_load  = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b00;
                    nextState    = S_DECODE;
                end
            end

            S_DECODE: begin
                if (decIllegal) begin
                    bus.illegal = 1'b1;
                    nextState   = S_FETCH;
                end else if (op == OP_MEM) begin
                    nextState = S_MEM;
                end else begin
                    nextState = S_EXEC;
                end
            end

            S_EXEC: begin
                nextState = S_FETCH;
                case (op)
                    OP_ALU, OP_ALUI: begin
                        bus.alu_fn      = fn;
                        bus.alu_src_imm = op[0];
                        bus.r2_sel      = 1'b1;
                        bus.flags_en    = 1'b1;
                        nextState       = S_WB;
                    end
                    OP_SHIFT: begin
                        bus.sh_fn = fn[1:0];
                        nextState = S_WB;
                    end
                    OP_BRANCH: begin
                        if (branchTaken) begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = 2'b01;
                        end
                    end
                    OP_JUMP: begin
                        case (fn)
                            FN_JMP: begin
                                bus.pc_write = 1'b1;
                                bus.pc_src   = 2'b10;
                            end
                            FN_JSR: begin
                                bus.stack_push = 1'b1;
                                bus.pc_write   = 1'b1;
                                bus.pc_src     = 2'b10;
                            end
                            FN_RET: begin
                                bus.stack_pop = 1'b1;
                                bus.pc_write  = 1'b1;
                                bus.pc_src    = 2'b11;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                if (fn == FN_LDM) begin
                    bus.dmem_read = 1'b1;
                    bus.r2_sel    = 1'b1;
                end else begin
                    bus.dmem_write = 1'b1;
                end
                if (bus.dmem_ready) begin
                    nextState = (fn == FN_LDM) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                bus.reg_write = 1'b1;
                if (op == OP_SHIFT) begin
                    bus.wb_sel = 2'b01;
                end else if (op == OP_MEM) begin
                    bus.wb_sel = 2'b10;
                end else begin
                    bus.wb_sel = 2'b00;
                end
                nextState = S_FETCH;
            end

            default: nextState = S_RST;
        endcase
    end
endmodule
